// File: rtl/zap_fetch_fifo.sv
// Instruction buffer between fetch and decode: a small circular FIFO with a
// one-cycle bypass, stall absorption, abort sleep and pipeline-clear flush.
module zap_fetch_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_decode,
    input  logic [31:0] i_instruction,
    input  logic        i_valid,
    input  logic        i_instr_abort,
    input  logic [31:0] i_pc_plus_8_ff,
    input  logic [31:0] i_pc_ff,
    input  logic [1:0]  i_taken,
    output logic        o_stall_to_fetch,
    output logic [31:0] o_instruction,
    output logic        o_valid,
    output logic        o_instr_abort,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [31:0] o_pc_ff,
    output logic [1:0]  o_taken_ff
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 99;

    // Entry layout: {instr[98:67], pc[66:35], pc+8[34:3], abort[2], taken[1:0]}
    function automatic logic [EW-1:0] pack_entry(
        input logic [31:0] instr,
        input logic [31:0] pc,
        input logic [31:0] pc8,
        input logic        abort,
        input logic [1:0]  taken
    );
        pack_entry = {instr, pc, pc8, abort, taken};
    endfunction

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          sleep_q, sleep_d;
    logic          stall_fetch_q;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] out_entry_q, out_entry_d;

    logic          any_stall_s;
    logic          clear_s;
    logic          accept_s;
    logic          we_s;
    logic [EW-1:0] in_entry_s;
    logic [EW-1:0] head_s;

    assign any_stall_s = i_data_stall | i_stall_from_shifter |
                         i_stall_from_issue | i_stall_from_decode;

    // A lower-priority clear is masked by any stall ranked above it.
    assign clear_s = i_clear_from_writeback |
                     (i_clear_from_alu & ~i_data_stall) |
                     (i_clear_from_decode & ~any_stall_s);

    assign accept_s   = i_valid & ~stall_fetch_q & ~sleep_q & ~clear_s;
    assign in_entry_s = pack_entry(i_instruction, i_pc_ff, i_pc_plus_8_ff,
                                   i_instr_abort, i_taken);
    assign head_s     = mem_q[rd_ptr_q];

    // Next-state: clear, then stall (push only), then pop / bypass / go idle.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        sleep_d     = sleep_q;
        out_valid_d = out_valid_q;
        out_entry_d = out_entry_q;
        we_s        = 1'b0;
        if (clear_s) begin
            rd_ptr_d       = {AW{1'b0}};
            wr_ptr_d       = {AW{1'b0}};
            count_d        = {CW{1'b0}};
            sleep_d        = 1'b0;
            out_valid_d    = 1'b0;
            out_entry_d[2] = 1'b0;
        end else begin
            sleep_d = sleep_q | (accept_s & i_instr_abort);
            if (any_stall_s) begin
                if (accept_s) begin
                    we_s     = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                end else begin
                    count_d = count_q;
                end
            end else if (count_q != {CW{1'b0}}) begin
                out_valid_d = 1'b1;
                out_entry_d = head_s;
                rd_ptr_d    = rd_ptr_q + AW'(1);
                if (accept_s) begin
                    we_s     = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end else begin
                    count_d = count_q - CW'(1);
                end
            end else if (accept_s) begin
                out_valid_d = 1'b1;
                out_entry_d = in_entry_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rd_ptr_q      <= {AW{1'b0}};
            wr_ptr_q      <= {AW{1'b0}};
            count_q       <= {CW{1'b0}};
            sleep_q       <= 1'b0;
            stall_fetch_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_entry_q   <= {EW{1'b0}};
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            sleep_q       <= sleep_d;
            stall_fetch_q <= (count_d >= CW'(DEPTH - 1));
            out_valid_q   <= out_valid_d;
            out_entry_q   <= out_entry_d;
        end
    end

    // Buffer storage, written only when an accepted entry cannot bypass.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
        end else begin
            if (we_s) begin
                mem_q[wr_ptr_q] <= in_entry_s;
            end
        end
    end

    assign o_stall_to_fetch = stall_fetch_q;
    assign o_valid          = out_valid_q;
    assign o_instruction    = out_entry_q[98:67];
    assign o_pc_ff          = out_entry_q[66:35];
    assign o_pc_plus_8_ff   = out_entry_q[34:3];
    assign o_instr_abort    = out_entry_q[2];
    assign o_taken_ff       = out_entry_q[1:0];

endmodule
